fifo36_framer: RTL and testbench

Converts an unframed 32-bit word stream into fifo36 packets (bit 32 SOF, bit 33 EOF, bits 35:34 occupancy) of programmable length. Each framer sits directly upstream of one input of the 2:1 fifo36 packet mux and feeds it complete, well-formed packets, so the mux always sees EOF and can rotate between ports. One registered output stage; full-throughput streaming.

---
 rtl/fifo36_framer.sv | 149 ++++++++++++++
 tb/tb_fifo36_framer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo36_framer.sv
// Frames an unframed 32-bit word stream into fifo36 packets of programmable length.
// Optional FRAMER_SEQNUM_EN prefixes each packet with a {16'h0, seqnum} header line.
module fifo36_framer #(
  parameter int MAX_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [MAX_LEN_W-1:0] frame_len,
  input  logic [31:0]          data_i,
  input  logic                 eof_i,
  input  logic                 src_rdy_i,
  output logic                 dst_rdy_o,
  output logic [35:0]          data_o,
  output logic                 src_rdy_o,
  input  logic                 dst_rdy_i,
  output logic [15:0]          pkt_count
);

`ifdef FRAMER_SEQNUM_EN
  typedef enum logic [1:0] {S_IDLE, S_BODY, S_HDR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_BODY} state_t;
`endif

  state_t               state_q, state_d;
  logic [MAX_LEN_W-1:0] len_q, len_d;
  logic [MAX_LEN_W-1:0] cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [35:0]          data_q, data_d;
  logic [15:0]          pkt_count_q, pkt_count_d;
`ifdef FRAMER_SEQNUM_EN
  logic [15:0]          seqnum_q, seqnum_d;
  logic                 hdr_sent_q, hdr_sent_d;
`endif

  logic                 space, in_open, acc, first, last, line_eof, line_sof;
  logic [MAX_LEN_W-1:0] len_new, len_m1;

  always_comb begin
    space    = ~valid_q | dst_rdy_i;
`ifdef FRAMER_SEQNUM_EN
    // Payload is only taken once this packet's header has been loaded.
    in_open  = (state_q == S_BODY) | ((state_q == S_IDLE) & hdr_sent_q);
    line_sof = 1'b0;
`else
    in_open  = 1'b1;
    line_sof = (state_q == S_IDLE);
`endif
    dst_rdy_o = space & in_open;
    acc       = src_rdy_i & dst_rdy_o;
    len_new   = (frame_len == '0) ? MAX_LEN_W'(1) : frame_len;
    len_m1    = len_q - MAX_LEN_W'(1);
    first     = (state_q == S_IDLE);
    last      = first ? (len_new == MAX_LEN_W'(1)) : (cnt_q == len_m1);
    line_eof  = eof_i | last;

    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    pkt_count_d = pkt_count_q;
`ifdef FRAMER_SEQNUM_EN
    seqnum_d    = seqnum_q;
    hdr_sent_d  = hdr_sent_q;
`endif

    if (space) begin
      valid_d = acc;
      if (acc) data_d = {2'b00, line_eof, line_sof, data_i};
    end

    case (state_q)
      S_IDLE: begin
`ifdef FRAMER_SEQNUM_EN
        if (!hdr_sent_q && src_rdy_i) state_d = S_HDR;
`endif
        if (acc) begin
          len_d = len_new;
          cnt_d = MAX_LEN_W'(1);
          if (line_eof) begin
            pkt_count_d = pkt_count_q + 16'd1;
`ifdef FRAMER_SEQNUM_EN
            hdr_sent_d  = 1'b0;
`endif
          end else begin
            state_d = S_BODY;
          end
        end
      end
      S_BODY: begin
        if (acc) begin
          cnt_d = cnt_q + MAX_LEN_W'(1);
          if (line_eof) begin
            state_d     = S_IDLE;
            pkt_count_d = pkt_count_q + 16'd1;
`ifdef FRAMER_SEQNUM_EN
            hdr_sent_d  = 1'b0;
`endif
          end
        end
      end
`ifdef FRAMER_SEQNUM_EN
      S_HDR: begin
        if (space) begin
          valid_d    = 1'b1;
          data_d     = {2'b00, 1'b0, 1'b1, 16'h0, seqnum_q};
          seqnum_d   = seqnum_q + 16'd1;
          hdr_sent_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      pkt_count_q <= '0;
`ifdef FRAMER_SEQNUM_EN
      seqnum_q    <= '0;
      hdr_sent_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      pkt_count_q <= pkt_count_d;
`ifdef FRAMER_SEQNUM_EN
      seqnum_q    <= seqnum_d;
      hdr_sent_q  <= hdr_sent_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign src_rdy_o = valid_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo36_framer.sv
// Directed-vector bench for fifo36_framer; output lines are captured and compared
// against hand-built expected packet lists.
module tb_fifo36_framer;
  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0;
  logic [15:0] frame_len = 16'd4;
  logic [31:0] data_i = '0;
  logic        eof_i = 1'b0, src_rdy_i = 1'b0, dst_rdy_i = 1'b1;
  logic        dst_rdy_o, src_rdy_o;
  logic [35:0] data_o;
  logic [15:0] pkt_count;

  fifo36_framer #(.MAX_LEN_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .frame_len(frame_len),
    .data_i(data_i), .eof_i(eof_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0, miscompares = 0, cyc = 0;
  logic [35:0] out_q[$], exp_q[$];
  int          out_cyc[$];
  bit          rand_bp = 1'b0, chk_stall = 1'b0, stall_prev = 1'b0;
  logic [35:0] held;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] ln(input bit e, input bit s, input logic [31:0] d);
    return {2'b00, e, s, d};
  endfunction

  // Transfers are judged at the negedge preceding the edge on which they happen.
  always @(negedge clk) begin
    cyc++;
    if (src_rdy_o && dst_rdy_i) begin
      out_q.push_back(data_o);
      out_cyc.push_back(cyc);
    end
    if (stall_prev) chk("stall_hold", {27'd0, src_rdy_o, data_o}, {27'd0, 1'b1, held});
    stall_prev = chk_stall && src_rdy_o && !dst_rdy_i;
    held = data_o;
  end

  initial forever begin
    @(posedge clk); #1;
    dst_rdy_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic push(input logic [31:0] d, input bit e);
    bit ok;
    int n;
    data_i = d; eof_i = e; src_rdy_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk); ok = dst_rdy_o;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) chk("push_timeout", 0, 1);
    src_rdy_i = 1'b0; eof_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end while (src_rdy_o && n < 100);
    if (src_rdy_o) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse(input bit use_clear);
    @(posedge clk); #1;
    if (use_clear) clear = 1'b1; else reset = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; reset = 1'b0;
    out_q.delete(); out_cyc.delete(); exp_q.delete();
  endtask

  task automatic check_out(input string name);
    chk({name, "_count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_line%0d", name, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_src_rdy", src_rdy_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_pkt", pkt_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dst_rdy", dst_rdy_o, 1);
    @(posedge clk); #1;

`ifdef FRAMER_SEQNUM_EN
    pulse(1'b1);
    frame_len = 16'd2;
    for (int i = 0; i < 4; i++) push(i, 1'b0);
    drain();
    exp_q = '{ln(0,1,32'h0), ln(0,0,0), ln(1,0,1), ln(0,1,32'h1), ln(0,0,2), ln(1,0,3)};
    check_out("seq");
    chk("seq_pkt", pkt_count, 2);
`else
    // Continuous stream, frame_len=4
    pulse(1'b1);
    frame_len = 16'd4;
    for (int i = 0; i < 12; i++) push(i, 1'b0);
    drain();
    for (int i = 0; i < 12; i++) exp_q.push_back(ln(i % 4 == 3, i % 4 == 0, i));
    check_out("len4");
    chk("len4_pkt", pkt_count, 3);
    if (out_cyc.size() == 12) chk("len4_span", out_cyc[11] - out_cyc[0], 11);
    else chk("len4_span_size", out_cyc.size(), 12);

    // Early close with eof_i
    pulse(1'b1);
    frame_len = 16'd8;
    push(0, 1'b0); push(1, 1'b0); push(2, 1'b1); push(3, 1'b0);
    drain();
    exp_q = '{ln(0,1,0), ln(0,0,1), ln(1,0,2), ln(0,1,3)};
    check_out("early");
    chk("early_pkt", pkt_count, 1);

    // frame_len 0 and 1 both mean single-line packets
    for (int l = 0; l < 2; l++) begin
      pulse(1'b1);
      frame_len = 16'(l);
      for (int i = 0; i < 3; i++) push(32'h50 + i, 1'b0);
      drain();
      for (int i = 0; i < 3; i++) exp_q.push_back(ln(1, 1, 32'h50 + i));
      check_out($sformatf("single%0d", l));
      chk($sformatf("single%0d_pkt", l), pkt_count, 3);
    end

    // Random backpressure
    pulse(1'b1);
    frame_len = 16'd4;
    rand_bp = 1'b1; chk_stall = 1'b1;
    for (int i = 0; i < 100; i++) push(32'h1000 + i, 1'b0);
    drain();
    rand_bp = 1'b0; chk_stall = 1'b0;
    for (int i = 0; i < 100; i++) exp_q.push_back(ln(i % 4 == 3, i % 4 == 0, 32'h1000 + i));
    check_out("bp");
    begin
      int eofs = 0;
      foreach (out_q[i]) if (out_q[i][33]) eofs++;
      chk("bp_eofs", eofs, 25);
    end
    chk("bp_pkt", pkt_count, 25);

    // Reset mid-packet discards the partial packet
    pulse(1'b1);
    frame_len = 16'd4;
    push(0, 1'b0); push(1, 1'b0); push(2, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_src_rdy", src_rdy_o, 0);
    chk("midrst_pkt", pkt_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h100 + i, 1'b0);
    drain();
    exp_q = '{ln(0,1,0), ln(0,0,1), ln(0,0,2),
              ln(0,1,32'h100), ln(0,0,32'h101), ln(0,0,32'h102), ln(1,0,32'h103)};
    check_out("midrst");
    chk("midrst_pkt_end", pkt_count, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
